// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD actuator-update controller:
// state encoding, default parameter values and width helpers.
package spgd_pkg;

    localparam int DEF_RAND_WIDTH     = 14;
    localparam int DEF_CTRL_WIDTH     = 14;
    localparam int DEF_METRIC_WIDTH   = 14;
    localparam int DEF_PERT_SHIFT     = 2;
    localparam int DEF_GAIN_SHIFT     = 10;
    localparam int DEF_SETTLE_CYCLES  = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        POS_SETTLE = 3'd1,
        POS_MEAS   = 3'd2,
        NEG_SETTLE = 3'd3,
        NEG_MEAS   = 3'd4,
        UPDATE     = 3'd5
    } spgd_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_adder.sv
// Signed adder with one guard bit, clamped to the signed OUT_W range.
// IN_W must be at least OUT_W.
module sat_adder #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 14
) (
    input  logic signed [IN_W-1:0]  a_i,
    input  logic signed [IN_W-1:0]  b_i,
    output logic signed [OUT_W-1:0] sum_o
);

    localparam int SW = IN_W + 1;
    localparam logic signed [SW-1:0] MAX_V = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [SW-1:0] sum_full;

    always_comb begin
        sum_full = {a_i[IN_W-1], a_i} + {b_i[IN_W-1], b_i};
        if (sum_full > MAX_V) begin
            sum_o = MAX_V[OUT_W-1:0];
        end else if (sum_full < MIN_V) begin
            sum_o = MIN_V[OUT_W-1:0];
        end else begin
            sum_o = sum_full[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/spgd_update.sv
// Two-sided SPGD iteration: perturb the actuator by +/-delta, measure the
// metric on each side, then step u along the measured gradient.
//   state      | meaning
//   IDLE       | ctrl_out = u, waiting for start
//   POS_SETTLE | ctrl_out = sat(u+delta), settle timer running
//   POS_MEAS   | waiting for J+ (timeout guarded)
//   NEG_SETTLE | ctrl_out = sat(u-delta), settle timer running
//   NEG_MEAS   | waiting for J- (timeout guarded)
//   UPDATE     | u <= sat(u + ((J+ - J-)*delta >>> GAIN_SHIFT))
module spgd_update
    import spgd_pkg::*;
#(
    parameter int RAND_WIDTH     = DEF_RAND_WIDTH,
    parameter int CTRL_WIDTH     = DEF_CTRL_WIDTH,
    parameter int METRIC_WIDTH   = DEF_METRIC_WIDTH,
    parameter int PERT_SHIFT     = DEF_PERT_SHIFT,
    parameter int GAIN_SHIFT     = DEF_GAIN_SHIFT,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic signed [RAND_WIDTH-1:0]   rand_in,
    input  logic                           metric_valid,
    input  logic        [METRIC_WIDTH-1:0] metric,
    output logic signed [CTRL_WIDTH-1:0]   ctrl_out,
    output logic                           meas_req,
    output logic                           busy,
    output logic                           done,
    output logic                           timeout_err
);

    localparam int DJ_W   = METRIC_WIDTH + 1;
    localparam int PROD_W = DJ_W + RAND_WIDTH;
    localparam int ADD_W  = max_int(PROD_W, CTRL_WIDTH) + 1;
    localparam int TMR_W  = $clog2(max_int(SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD  = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    spgd_state_e                    state_q, state_d;
    logic signed [CTRL_WIDTH-1:0]   u_q, u_d;
    logic signed [RAND_WIDTH-1:0]   delta_q, delta_d;
    logic        [METRIC_WIDTH-1:0] jp_q, jp_d, jm_q, jm_d;
    logic        [TMR_W-1:0]        tmr_q, tmr_d;
    logic                           meas_req_q, meas_req_d;
    logic                           done_q, done_d;
    logic                           tmo_q, tmo_d;

    logic signed [DJ_W-1:0]         dj;
    logic signed [PROD_W-1:0]       prod, step;
    logic signed [ADD_W-1:0]        u_ext, delta_ext, delta_neg, step_ext;
    logic signed [CTRL_WIDTH-1:0]   ctrl_pos, ctrl_neg, u_upd;

    // All operands are widened before the saturating add so nothing wraps.
    assign dj        = $signed({1'b0, jp_q}) - $signed({1'b0, jm_q});
    assign prod      = PROD_W'(dj) * PROD_W'(delta_q);
    assign step      = prod >>> GAIN_SHIFT;
    assign u_ext     = ADD_W'(u_q);
    assign delta_ext = ADD_W'(delta_q);
    assign delta_neg = -delta_ext;
    assign step_ext  = ADD_W'(step);

    sat_adder #(.IN_W(ADD_W), .OUT_W(CTRL_WIDTH)) u_add_pos (
        .a_i(u_ext), .b_i(delta_ext), .sum_o(ctrl_pos)
    );

    sat_adder #(.IN_W(ADD_W), .OUT_W(CTRL_WIDTH)) u_add_neg (
        .a_i(u_ext), .b_i(delta_neg), .sum_o(ctrl_neg)
    );

    sat_adder #(.IN_W(ADD_W), .OUT_W(CTRL_WIDTH)) u_add_upd (
        .a_i(u_ext), .b_i(step_ext), .sum_o(u_upd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            u_q        <= '0;
            delta_q    <= '0;
            jp_q       <= '0;
            jm_q       <= '0;
            tmr_q      <= '0;
            meas_req_q <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            u_q        <= u_d;
            delta_q    <= delta_d;
            jp_q       <= jp_d;
            jm_q       <= jm_d;
            tmr_q      <= tmr_d;
            meas_req_q <= meas_req_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        u_d        = u_q;
        delta_d    = delta_q;
        jp_d       = jp_q;
        jm_d       = jm_q;
        tmr_d      = tmr_q;
        meas_req_d = 1'b0;
        done_d     = 1'b0;
        tmo_d      = tmo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    delta_d = rand_in >>> PERT_SHIFT;
                    tmo_d   = 1'b0;
                    tmr_d   = SETTLE_LOAD;
                    state_d = POS_SETTLE;
                end
            end
            POS_SETTLE: begin
                if (tmr_q == '0) begin
                    meas_req_d = 1'b1;
                    tmr_d      = TIMEOUT_LOAD;
                    state_d    = POS_MEAS;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            POS_MEAS: begin
                if (metric_valid) begin
                    jp_d    = metric;
                    tmr_d   = SETTLE_LOAD;
                    state_d = NEG_SETTLE;
                end else if (tmr_q == '0) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            NEG_SETTLE: begin
                if (tmr_q == '0) begin
                    meas_req_d = 1'b1;
                    tmr_d      = TIMEOUT_LOAD;
                    state_d    = NEG_MEAS;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            NEG_MEAS: begin
                if (metric_valid) begin
                    jm_d    = metric;
                    state_d = UPDATE;
                end else if (tmr_q == '0) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            UPDATE: begin
                u_d     = u_upd;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            POS_SETTLE, POS_MEAS: ctrl_out = ctrl_pos;
            NEG_SETTLE, NEG_MEAS: ctrl_out = ctrl_neg;
            default:              ctrl_out = u_q;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign meas_req    = meas_req_q;
    assign done        = done_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_spgd_update.sv
// Directed bench for spgd_update: an arithmetic model of each iteration sets
// per-cycle expectations that a negedge compare process checks.
module tb_spgd_update;

    localparam int RW     = 14;
    localparam int CW     = 14;
    localparam int MW     = 14;
    localparam int PS     = 2;
    localparam int GS     = 10;
    localparam int SETTLE = 16;
    localparam int TMO    = 1024;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic signed [RW-1:0] rand_in;
    logic                 metric_valid;
    logic        [MW-1:0] metric;
    logic signed [CW-1:0] ctrl_out;
    logic                 meas_req;
    logic                 busy;
    logic                 done;
    logic                 timeout_err;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    int exp_ctrl = 0;
    bit exp_busy = 1'b0;
    bit exp_meas = 1'b0;
    bit exp_done = 1'b0;
    bit exp_tmo  = 1'b0;

    int m_u   = 0;
    bit m_tmo = 1'b0;
    int last_cp = 0;
    int last_cn = 0;

    always #5 clk = ~clk;

    spgd_update #(
        .RAND_WIDTH(RW), .CTRL_WIDTH(CW), .METRIC_WIDTH(MW),
        .PERT_SHIFT(PS), .GAIN_SHIFT(GS),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rand_in(rand_in),
        .metric_valid(metric_valid), .metric(metric),
        .ctrl_out(ctrl_out), .meas_req(meas_req), .busy(busy),
        .done(done), .timeout_err(timeout_err)
    );

    function automatic int floor_div_pow2(input int a, input int sh);
        int d;
        int q;
        d = 1 << sh;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int clamp(input int v);
        int lo;
        int hi;
        lo = -(1 << (CW - 1));
        hi = (1 << (CW - 1)) - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ctrl_out",    32'(ctrl_out),    32'(exp_ctrl));
            chk("busy",        32'(busy),        32'(exp_busy));
            chk("meas_req",    32'(meas_req),    32'(exp_meas));
            chk("done",        32'(done),        32'(exp_done));
            chk("timeout_err", 32'(timeout_err), 32'(exp_tmo));
        end
    end

    // Inputs set before a tick are sampled at its edge; expectations describe
    // the outputs after that edge.
    task automatic tick(input int c, input bit b, input bit m, input bit d);
        @(posedge clk);
        #1;
        exp_ctrl = c;
        exp_busy = b;
        exp_meas = m;
        exp_done = d;
        exp_tmo  = m_tmo;
    endtask

    task automatic iter(input int r, input int jp, input int jm,
                        input bit tmo_pos, input bit noise, input bit rst_neg);
        int d;
        int cp;
        int cn;
        int u_new;
        d       = floor_div_pow2(r, PS);
        cp      = clamp(m_u + d);
        cn      = clamp(m_u - d);
        u_new   = clamp(m_u + floor_div_pow2((jp - jm) * d, GS));
        last_cp = cp;
        last_cn = cn;

        start   = 1'b1;
        rand_in = RW'(r);
        m_tmo   = 1'b0;
        tick(cp, 1, 0, 0);
        start   = 1'b0;
        for (int i = 1; i < SETTLE; i++) begin
            if (noise) begin
                metric_valid = 1'b1;
                metric       = MW'(12345);
            end
            tick(cp, 1, 0, 0);
        end
        metric_valid = 1'b0;
        tick(cp, 1, 1, 0);

        if (tmo_pos) begin
            for (int i = 1; i < TMO; i++) tick(cp, 1, 0, 0);
            m_tmo = 1'b1;
            tick(m_u, 0, 0, 0);
            tick(m_u, 0, 0, 0);
            return;
        end

        repeat (3) tick(cp, 1, 0, 0);
        metric_valid = 1'b1;
        metric       = MW'(jp);
        tick(cn, 1, 0, 0);
        metric_valid = 1'b0;
        for (int i = 1; i < SETTLE; i++) begin
            if (noise) start = 1'b1;
            tick(cn, 1, 0, 0);
        end
        start = 1'b0;
        tick(cn, 1, 1, 0);

        if (rst_neg) begin
            tick(cn, 1, 0, 0);
            chk_en = 1'b0;
            rst    = 1'b0;
            #1;
            chk("rst_mid_ctrl_out", 32'(ctrl_out),    0);
            chk("rst_mid_busy",     32'(busy),        0);
            chk("rst_mid_meas_req", 32'(meas_req),    0);
            chk("rst_mid_done",     32'(done),        0);
            chk("rst_mid_tmo",      32'(timeout_err), 0);
            m_u   = 0;
            m_tmo = 1'b0;
            return;
        end

        repeat (2) tick(cn, 1, 0, 0);
        metric_valid = 1'b1;
        metric       = MW'(jm);
        tick(m_u, 1, 0, 0);
        metric_valid = 1'b0;
        m_u = u_new;
        tick(m_u, 0, 0, 1);
        tick(m_u, 0, 0, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b1;
        exp_ctrl = 0;
        exp_busy = 1'b0;
        exp_meas = 1'b0;
        exp_done = 1'b0;
        exp_tmo  = 1'b0;
        chk_en   = 1'b1;
        tick(m_u, 0, 0, 0);
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        rand_in      = '0;
        metric_valid = 1'b0;
        metric       = '0;
        #2;
        chk("reset_ctrl_out", 32'(ctrl_out),    0);
        chk("reset_busy",     32'(busy),        0);
        chk("reset_meas_req", 32'(meas_req),    0);
        chk("reset_done",     32'(done),        0);
        chk("reset_tmo",      32'(timeout_err), 0);
        release_reset();

        // Basic iteration: delta 100, dJ 400 -> u = 39
        iter(400, 1000, 600, 0, 0, 0);
        chk("iter_pos_ctrl", last_cp, 100);
        chk("iter_neg_ctrl", last_cn, -100);
        chk("iter_model_u", m_u, 39);
        chk("iter_u", 32'(ctrl_out), 39);

        // dJ = -1 floors to a step of -1
        iter(400, 600, 601, 0, 0, 0);
        chk("floor_u", 32'(ctrl_out), 38);

        // Large step to reach u = 8100
        iter(4000, 8256, 0, 0, 0, 0);
        chk("big_step_u", 32'(ctrl_out), 8100);

        // Saturation of the positive perturbation
        iter(4000, 5000, 5000, 0, 0, 0);
        chk("sat_pos_ctrl", last_cp, 8191);
        chk("sat_neg_ctrl", last_cn, 7100);
        chk("sat_u", 32'(ctrl_out), 8100);

        // Reset asserted during NEG_MEAS, then a clean iteration with
        // stray start/metric_valid that must be ignored
        iter(400, 1000, 600, 0, 1, 1);
        release_reset();
        iter(400, 1000, 600, 0, 1, 0);
        chk("noise_u", 32'(ctrl_out), 39);

        // Timeout in POS_MEAS
        iter(1200, 0, 0, 1, 0, 0);
        chk("tmo_flag", 32'(timeout_err), 1);
        chk("tmo_ctrl", 32'(ctrl_out), 39);
        chk("tmo_busy", 32'(busy), 0);

        // Negative delta with floor on rand_in; timeout_err cleared by start
        iter(-401, 500, 1000, 0, 0, 0);
        chk("negdelta_pos_ctrl", last_cp, -62);
        chk("negdelta_neg_ctrl", last_cn, 140);
        chk("negdelta_u", 32'(ctrl_out), 88);
        chk("tmo_cleared", 32'(timeout_err), 0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
